// File: rtl/alu_decode_if.sv
// Handshake and bus bundle between the fetch/regfile side, the RV32I ALU decode stage
// and the execute stage.
interface alu_decode_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;

  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_op;
  logic [31:0] in1;
  logic [31:0] in2;
  logic [4:0]  rd;
  logic        rd_we;
  logic        illegal;
  logic [15:0] illegal_cnt;

  modport master (
    output in_valid, instr, pc, rs1_data, rs2_data, flush, out_ready,
    input  in_ready, out_valid, alu_op, in1, in2, rd, rd_we, illegal, illegal_cnt
  );

  modport slave (
    input  in_valid, instr, pc, rs1_data, rs2_data, flush, out_ready,
    output in_ready, out_valid, alu_op, in1, in2, rd, rd_we, illegal, illegal_cnt
  );
endinterface

// File: rtl/alu_decode.sv
// Single-entry registered RV32I ALU decode stage: turns OP/OP-IMM/LUI/AUIPC words into
// an ALU opcode plus operands, flags anything else as illegal and counts illegal bundles.
module alu_decode (
`ifdef USE_POWER_PINS
  inout              vccd1,
  inout              vssd1,
`endif
  input  logic       clk,
  input  logic       rst,
  alu_decode_if.slave bus
);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } alu_op_e;

  typedef enum logic [6:0] {
    OPC_OP     = 7'b0110011,
    OPC_OP_IMM = 7'b0010011,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111
  } opcode_e;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;
  localparam logic [2:0] F3_ADD      = 3'b000;
  localparam logic [2:0] F3_SLL      = 3'b001;
  localparam logic [2:0] F3_SR       = 3'b101;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  dec_rd;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic [31:0] shamt;

  logic [3:0]  dec_alu_op;
  logic [31:0] dec_in1;
  logic [31:0] dec_in2;
  logic        dec_illegal;
  logic        dec_rd_we;

  logic        out_valid_q,   out_valid_d;
  logic [3:0]  alu_op_q,      alu_op_d;
  logic [31:0] in1_q,         in1_d;
  logic [31:0] in2_q,         in2_d;
  logic [4:0]  rd_q,          rd_d;
  logic        rd_we_q,       rd_we_d;
  logic        illegal_q,     illegal_d;
  logic [15:0] illegal_cnt_q, illegal_cnt_d;

  logic        in_ready;
  logic        accept;
  logic        drain;

  assign opcode = bus.instr[6:0];
  assign funct3 = bus.instr[14:12];
  assign funct7 = bus.instr[31:25];
  assign dec_rd = bus.instr[11:7];
  assign imm_i  = {{20{bus.instr[31]}}, bus.instr[31:20]};
  assign imm_u  = {bus.instr[31:12], 12'b0};
  assign shamt  = {27'b0, bus.instr[24:20]};

  always_comb begin
    dec_alu_op  = ALU_ADD;
    dec_in1     = '0;
    dec_in2     = '0;
    dec_illegal = 1'b0;

    case (opcode)
      OPC_OP: begin
        dec_in1 = bus.rs1_data;
        dec_in2 = bus.rs2_data;
        if (funct7 == FUNCT7_BASE) begin
          dec_alu_op = {1'b0, funct3};
        end else if (funct7 == FUNCT7_ALT && (funct3 == F3_ADD || funct3 == F3_SR)) begin
          dec_alu_op = {1'b1, funct3};
        end else begin
          dec_illegal = 1'b1;
        end
      end

      OPC_OP_IMM: begin
        dec_in1 = bus.rs1_data;
        case (funct3)
          F3_SLL: begin
            dec_in2    = shamt;
            dec_alu_op = ALU_SLL;
            if (funct7 != FUNCT7_BASE) dec_illegal = 1'b1;
          end
          F3_SR: begin
            dec_in2    = shamt;
            dec_alu_op = {bus.instr[30], F3_SR};
            if (funct7 != FUNCT7_BASE && funct7 != FUNCT7_ALT) dec_illegal = 1'b1;
          end
          default: begin
            dec_in2    = imm_i;
            dec_alu_op = {1'b0, funct3};
          end
        endcase
      end

      OPC_LUI: begin
        dec_in2 = imm_u;
      end

      OPC_AUIPC: begin
        dec_in1 = bus.pc;
        dec_in2 = imm_u;
      end

      default: begin
        dec_illegal = 1'b1;
      end
    endcase

    // Illegal words deliver a neutral ADD 0,0 so execute never sees stale operands.
    if (dec_illegal) begin
      dec_alu_op = ALU_ADD;
      dec_in1    = '0;
      dec_in2    = '0;
    end

    dec_rd_we = !dec_illegal && (dec_rd != 5'd0);
  end

  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready && !bus.flush;
  assign drain    = out_valid_q && bus.out_ready;

  always_comb begin
    out_valid_d   = out_valid_q;
    alu_op_d      = alu_op_q;
    in1_d         = in1_q;
    in2_d         = in2_q;
    rd_d          = rd_q;
    rd_we_d       = rd_we_q;
    illegal_d     = illegal_q;
    illegal_cnt_d = illegal_cnt_q;

    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      alu_op_d    = dec_alu_op;
      in1_d       = dec_in1;
      in2_d       = dec_in2;
      rd_d        = dec_rd;
      rd_we_d     = dec_rd_we;
      illegal_d   = dec_illegal;
      if (dec_illegal && illegal_cnt_q != '1) begin
        illegal_cnt_d = illegal_cnt_q + 16'd1;
      end
    end else if (drain) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      alu_op_q      <= '0;
      in1_q         <= '0;
      in2_q         <= '0;
      rd_q          <= '0;
      rd_we_q       <= 1'b0;
      illegal_q     <= 1'b0;
      illegal_cnt_q <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      alu_op_q      <= alu_op_d;
      in1_q         <= in1_d;
      in2_q         <= in2_d;
      rd_q          <= rd_d;
      rd_we_q       <= rd_we_d;
      illegal_q     <= illegal_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.alu_op      = alu_op_q;
  assign bus.in1         = in1_q;
  assign bus.in2         = in2_q;
  assign bus.rd          = rd_q;
  assign bus.rd_we       = rd_we_q;
  assign bus.illegal     = illegal_q;
  assign bus.illegal_cnt = illegal_cnt_q;

endmodule

// File: doc/alu_decode.md
ALU_DECODE -- requirements
Module: alu_decode

Interface
REQ-001 Parameter: none; all widths are fixed for RV32I.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Power pins: vccd1 and vssd1 are inout, present only when USE_POWER_PINS is defined.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  instruction/operand bundle valid.
REQ-007 in_ready  out  1  block can accept a bundle this cycle.
REQ-008 instr  in  32  RV32I instruction word.
REQ-009 pc  in  32  address of instr.
REQ-010 rs1_data, rs2_data  in  32 each  register-file read values for instr.
REQ-011 flush  in  1  discard the held and incoming bundle.
REQ-012 out_valid  out  1  decoded bundle valid.
REQ-013 out_ready  in  1  downstream execute stage accepts the bundle.
REQ-014 alu_op  out  4  ALU opcode: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
REQ-015 in1, in2  out  32 each  ALU operands.
REQ-016 rd  out  5  destination register index.
REQ-017 rd_we  out  1  register writeback enable.
REQ-018 illegal  out  1  instruction not decodable by this block.
REQ-019 illegal_cnt  out  16  saturating count of illegal bundles delivered.

Function
REQ-020 The block SHALL be a single-entry registered stage with in_ready = !out_valid | out_ready (combinational).
REQ-021 Accept: when in_valid & in_ready & !flush, decoded outputs SHALL register on that edge, and out_valid SHALL be 1 the next cycle (latency 1).
REQ-022 Drain: when out_valid & out_ready and no accept occurs, out_valid SHALL go to 0 next cycle; accept and drain in the same cycle SHALL keep out_valid=1 with the new bundle.
REQ-023 Stall: while out_valid & !out_ready, all outputs SHALL hold stable.
REQ-024 Flush: flush=1 SHALL clear out_valid next cycle and SHALL override any simultaneous accept; illegal_cnt is unchanged.
REQ-025 OP (opcode 0110011), funct7 0000000: alu_op = {0, funct3}, in1 = rs1_data, in2 = rs2_data.
REQ-026 OP, funct7 0100000: legal only for funct3 000 or 101, with alu_op = {1, funct3}; any other funct7 or funct3 combination is illegal.
REQ-027 OP-IMM (0010011), funct3 other than 001 and 101: alu_op = {0, funct3}, in1 = rs1_data, in2 = sign-extended instr[31:20].
REQ-028 OP-IMM shifts: funct3 001 requires instr[31:25] = 0000000. funct3 101 requires instr[31:25] = 0000000 or 0100000, with alu_op = {instr[30], 101}. For both, in2 = {27'b0, instr[24:20]}; any other funct7 is illegal.
REQ-029 LUI (0110111): alu_op = ADD, in1 = 0, in2 = {instr[31:12], 12'b0}.
REQ-030 AUIPC (0010111): alu_op = ADD, in1 = pc, in2 = {instr[31:12], 12'b0}.
REQ-031 Any other opcode, or a violation of REQ-026/REQ-028, SHALL set illegal=1, alu_op = ADD, in1 = in2 = 0, rd_we = 0; the bundle is still delivered with out_valid.
REQ-032 rd = instr[11:7]. rd_we = 1 for legal bundles with rd != 0, else 0.
REQ-033 illegal_cnt SHALL increment by 1 on each accepted illegal bundle and saturate at 0xFFFF.

Reset
REQ-034 On rst=1 at a clock edge: out_valid=0, alu_op=0, in1=in2=0, rd=0, rd_we=0, illegal=0, illegal_cnt=0.
REQ-035 rst SHALL override flush, accept and drain; in_ready SHALL be 1 in the first cycle after reset.

Verification
REQ-036 instr=0x002081B3 (add x3,x1,x2), rs1_data=5, rs2_data=7, out_ready=1 -> next cycle: out_valid=1, alu_op=0000, in1=5, in2=7, rd=3, rd_we=1, illegal=0.
REQ-037 instr=0x40335293 (srai x5,x6,3) -> alu_op=1101, in2=0x00000003, rd=5. instr=0xFFF00093 (addi x1,x0,-1) -> alu_op=0000, in2=0xFFFFFFFF.
REQ-038 instr=0x123450B7 (lui x1,0x12345) -> in1=0, in2=0x12345000, alu_op=0000. With pc=0x100 and auipc encoding 0x12345097 -> in1=0x100.
REQ-039 Bundle A delivered, out_ready=0 for 3 cycles with bundle B held on the input -> in_ready=0 and outputs stable at A. Then out_ready=1 -> B appears the next cycle with no bubble and no loss.
REQ-040 instr=0x0000007F, and instr=0x40001033 (funct7=0100000, funct3=001) -> illegal=1, rd_we=0, illegal_cnt 0->1->2. After forcing 65535 illegal bundles, the count holds at 0xFFFF.
REQ-041 flush=1 in the same cycle as an accept -> out_valid=0 next cycle. rst mid-stall -> all outputs 0 next cycle, in_ready=1.
